fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 8 +
 rtl/fetch_fifo.sv | 58 +++++
 rtl/fetch_unit.sv | 83 ++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU-wide constants used by the pipeline and front-end blocks.
package cpu_pkg;

    localparam int unsigned PIPE_WORD_SIZE  = 16;
    localparam int unsigned FETCH_WORD_SIZE = PIPE_WORD_SIZE;
    localparam logic [FETCH_WORD_SIZE-1:0] FETCH_RESET_PC = 16'h0023;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH-deep FIFO with synchronous write, pop and clear.
module fetch_fifo #(
    parameter int unsigned WIDTH = 48,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             Clk,
    input  logic             Reset_N,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             do_wr;
    logic             do_pop;

    // Clear wins over everything; full/empty guards keep count in range.
    assign do_wr   = wr_en && !clear && (count < CNT_W'(DEPTH));
    assign do_pop  = pop && !clear && (count != '0);
    assign rd_data = mem[rd_ptr];

    // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(do_wr) - CNT_W'(do_pop);
        end
    end

    // Entry storage, no reset needed since count gates visibility.
    always_ff @(posedge Clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: drives memory requests, buffers responses, handles redirect/halt.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int unsigned          WORD_SIZE = FETCH_WORD_SIZE,
    parameter int unsigned          DEPTH     = 4,
    parameter logic [WORD_SIZE-1:0] RESET_PC  = WORD_SIZE'(FETCH_RESET_PC)
) (
    input  logic                 Clk,
    input  logic                 Reset_N,
    output logic                 readM,
    output logic [WORD_SIZE-1:0] address,
    input  logic [WORD_SIZE-1:0] data,
    input  logic                 mem_ready,
    output logic                 inst_valid,
    output logic [WORD_SIZE-1:0] inst,
    output logic [WORD_SIZE-1:0] inst_pc,
    output logic [WORD_SIZE-1:0] inst_num,
    input  logic                 stall,
    input  logic                 redirect,
    input  logic [WORD_SIZE-1:0] redirect_pc,
    input  logic                 halt,
    output logic                 is_halted
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = 3 * WORD_SIZE;

    logic [WORD_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] seq;
    logic                 fetch_en;
    logic [CNT_W-1:0]     count;
    logic                 accept;
    logic                 wr_en;
    logic                 pop;
    logic [ENT_W-1:0]     head;

    // A request is live only while enabled, not halted and the buffer has room.
    assign readM      = fetch_en && !is_halted && (count < CNT_W'(DEPTH));
    assign accept     = readM && mem_ready;
    assign wr_en      = accept && !redirect;
    assign pop        = inst_valid && !stall && !redirect;
    assign address    = pc;
    assign inst_valid = (count != '0);
    assign {inst, inst_pc, inst_num} = head;

    // pc, sequence number, fetch enable and sticky halt.
    always_ff @(posedge Clk) begin
        if (!Reset_N) begin
            pc        <= RESET_PC;
            seq       <= WORD_SIZE'(1);
            fetch_en  <= 1'b0;
            is_halted <= 1'b0;
        end else begin
            fetch_en <= 1'b1;
            if (halt) begin
                is_halted <= 1'b1;
            end
            if (redirect) begin
                pc <= redirect_pc;
            end else if (accept) begin
                pc  <= pc + WORD_SIZE'(1);
                seq <= seq + WORD_SIZE'(1);
            end
        end
    end

    // Buffer of {instruction, fetch address, sequence number}.
    fetch_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk     (Clk),
        .Reset_N (Reset_N),
        .wr_en   (wr_en),
        .wr_data ({data, pc, seq}),
        .pop     (pop),
        .clear   (redirect),
        .rd_data (head),
        .count   (count)
    );

endmodule
